// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// frame field widths and the running checksum step.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  // Frame checksum is a plain byte-wise XOR over the data bytes.
  function automatic logic [BYTE_W-1:0] csum_step(input logic [BYTE_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an LSB-first byte stream into 32-bit little-endian words; the finished
// word is held in its own register so later bytes cannot disturb it.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [1:0]  cnt,
  output logic        word_done
);

  logic [23:0] shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  // Next-state for the shift register, byte count and completed word.
  always_comb begin
    shift_d = shift_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (clr) begin
      shift_d = 24'd0;
      word_d  = 32'd0;
      cnt_d   = 2'd0;
    end else if (load) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        word_d = {din, shift_q};
        done_d = 1'b1;
      end else begin
        shift_d = {din, shift_q[23:8]};
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= 24'd0;
      word_q  <= 32'd0;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign word      = word_q;
  assign cnt       = cnt_q;
  assign word_done = done_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses LEN/data/CSUM frames, writes
// packed words and releases the core reset once the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_rst_n,
  output logic        done,
  output logic        error
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_idx_q, word_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       addr_q, addr_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              core_rst_n_q, core_rst_n_d;

  logic              accept_s;
  logic              pk_load_s;
  logic              pk_clr_s;
  logic [1:0]        pk_cnt_s;
  logic [LEN_W-1:0]  len_rx_s;

  assign rx_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA)   || (state_q == ST_CHECK);
  assign accept_s = rx_valid && rx_ready;
  assign len_rx_s = {rx_data, len_q[7:0]};

  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr_s),
    .load      (pk_load_s),
    .din       (rx_data),
    .word      (wr_data),
    .cnt       (pk_cnt_s),
    .word_done (wr_en)
  );

  // Frame FSM, word counter, address and checksum next-state.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    pk_load_s  = 1'b0;
    pk_clr_s   = 1'b0;
    case (state_q)
      ST_LEN_LO: begin
        if (accept_s) begin
          len_d   = {8'd0, rx_data};
          state_d = ST_LEN_HI;
        end else begin
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          len_d = len_rx_s;
          if ({1'b0, len_rx_s} > 17'(IMEM_DEPTH)) begin
            state_d = ST_ERROR;
          end else if (len_rx_s == 16'd0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_LEN_HI;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          pk_load_s = 1'b1;
          csum_d    = csum_step(csum_q, rx_data);
          if (pk_cnt_s == 2'd3) begin
            addr_d     = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            word_idx_d = word_idx_q + 16'd1;
            // Compare in 17 bits so the last-word test cannot wrap.
            if (({1'b0, word_idx_q} + 17'd1) == {1'b0, len_q}) begin
              state_d = ST_CHECK;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CHECK: begin
        if (accept_s) begin
          state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          state_d    = ST_LEN_LO;
          len_d      = 16'd0;
          word_idx_d = 16'd0;
          csum_d     = 8'd0;
          pk_clr_s   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_LEN_LO;
      end
    endcase
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERROR);
    core_rst_n_d = (state_d == ST_DONE);
  end

  // Loader state and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LEN_LO;
      len_q        <= 16'd0;
      word_idx_q   <= 16'd0;
      csum_q       <= 8'd0;
      addr_q       <= 32'd0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      csum_q       <= csum_d;
      addr_q       <= addr_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign wr_addr    = addr_q;
  assign done       = done_q;
  assign error      = error_q;
  assign core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are fed byte by byte and the write
// port is logged by a negedge monitor.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        reload;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_rst_n;
  logic        done;
  logic        error;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int wr_n = 0;
  logic [31:0] wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];
  int          wr_cyc_log  [0:63];

  imem_loader #(.IMEM_DEPTH(256), .BASE_ADDR(32'd0)) dut (
    .clk(clk), .rst(rst), .reload(reload), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .core_rst_n(core_rst_n),
    .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1 && wr_n < 64) begin
      wr_addr_log[wr_n] = wr_addr;
      wr_data_log[wr_n] = wr_data;
      wr_cyc_log[wr_n]  = cyc;
      wr_n = wr_n + 1;
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_byte_timeout: rx_ready got %b expected 1", rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps && $urandom_range(1) == 1) idle(1);
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({wr_en, wr_addr, wr_data, core_rst_n, done, error, rx_ready} !==
        {1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h crn=%b done=%b err=%b rdy=%b expected 0 0 0 0 0 0 1",
               wr_en, wr_addr, wr_data, core_rst_n, done, error, rx_ready);
    end
  endtask

  task automatic test_single_word();
    int base;
    base = wr_n;
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h00000513, 1'b0);
    send_byte(8'h16);
    rx_valid = 1'b0;
    chk("t1_done_next_cycle", {31'd0, done}, 32'd1);
    chk("t1_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    idle(2);
    chk("t1_write_count", wr_n - base, 32'd1);
    chk("t1_addr", wr_addr_log[base], 32'h0);
    chk("t1_data", wr_data_log[base], 32'h00000513);
    chk("t1_error", {31'd0, error}, 32'd0);
    pulse_reload();
    chk("t1_reload_clears_done", {31'd0, done}, 32'd0);
    chk("t1_reload_ready", {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic test_back_to_back();
    int base, c0, c1;
    base = wr_n;
    c0 = cyc;
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h00100093, 1'b0);
    send_word(32'h00208113, 1'b0);
    send_byte(8'h31);
    c1 = cyc;
    rx_valid = 1'b0;
    idle(2);
    chk("t2_no_stall_cycles", c1 - c0, 32'd11);
    chk("t2_write_count", wr_n - base, 32'd2);
    chk("t2_addr0", wr_addr_log[base], 32'h0);
    chk("t2_data0", wr_data_log[base], 32'h00100093);
    chk("t2_addr1", wr_addr_log[base+1], 32'h4);
    chk("t2_data1", wr_data_log[base+1], 32'h00208113);
    chk("t2_write_spacing", wr_cyc_log[base+1] - wr_cyc_log[base], 32'd4);
    chk("t2_done", {31'd0, done}, 32'd1);
    pulse_reload();
  endtask

  task automatic test_bad_csum();
    int base;
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h00000513, 1'b0);
    send_byte(8'h17);
    idle(2);
    chk("t3_error", {31'd0, error}, 32'd1);
    chk("t3_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("t3_done", {31'd0, done}, 32'd0);
    chk("t3_not_ready", {31'd0, rx_ready}, 32'd0);
    pulse_reload();
    chk("t3_reload_clears_error", {31'd0, error}, 32'd0);
    base = wr_n;
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h00000513, 1'b0);
    send_byte(8'h16);
    idle(2);
    chk("t3_retry_done", {31'd0, done}, 32'd1);
    chk("t3_retry_addr", wr_addr_log[base], 32'h0);
    pulse_reload();
  endtask

  task automatic test_length_bounds();
    int base;
    base = wr_n;
    send_byte(8'h01); send_byte(8'h01);
    rx_valid = 1'b0;
    chk("t4_too_long_error", {31'd0, error}, 32'd1);
    idle(3);
    chk("t4_too_long_no_write", wr_n - base, 32'd0);
    pulse_reload();
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    idle(2);
    chk("t4_zero_len_done", {31'd0, done}, 32'd1);
    chk("t4_zero_len_no_write", wr_n - base, 32'd0);
    pulse_reload();
  endtask

  task automatic test_random_gaps();
    int base;
    logic [31:0] w;
    logic [7:0] cs;
    base = wr_n;
    cs = 8'h00;
    send_byte(8'h08); send_byte(8'h00);
    for (int i = 0; i < 8; i++) begin
      w = 32'hA0B1C2D3 ^ (32'h01010101 * i);
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_word(w, 1'b1);
    end
    if ($urandom_range(1) == 1) idle(1);
    send_byte(cs);
    idle(2);
    chk("t5_write_count", wr_n - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      w = 32'hA0B1C2D3 ^ (32'h01010101 * i);
      chk($sformatf("t5_addr%0d", i), wr_addr_log[base+i], 32'(4 * i));
      chk($sformatf("t5_data%0d", i), wr_data_log[base+i], w);
    end
    chk("t5_done", {31'd0, done}, 32'd1);
    pulse_reload();
  endtask

  task automatic test_async_reset();
    int base;
    base = wr_n;
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h12345678, 1'b0);
    send_byte(8'h9A); send_byte(8'hBC);
    rx_valid = 1'b0;
    chk("t6_pre_reset_write", wr_n - base, 32'd1);
    chk("t6_pre_reset_data", wr_data, 32'h12345678);
    #2 rst = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = wr_n;
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'hDEADBEEF, 1'b0);
    send_byte(8'h22);
    idle(2);
    chk("t6_fresh_count", wr_n - base, 32'd1);
    chk("t6_fresh_addr", wr_addr_log[base], 32'h0);
    chk("t6_fresh_data", wr_data_log[base], 32'hDEADBEEF);
    chk("t6_fresh_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    reload = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_single_word();
    test_back_to_back();
    test_bad_csum();
    test_length_bounds();
    test_random_gaps();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
